// File: rtl/reg_file_rename_pkg.sv
// Shared widths and constants for the renaming architectural register file.
package reg_file_rename_pkg;

    localparam int unsigned RF_REG_WIDTH  = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_TAG_WIDTH  = 4;
    localparam int unsigned RF_NUM_REGS   = 1 << RF_REG_WIDTH;

    // All-ones tag means "no pending producer".
    localparam logic [RF_TAG_WIDTH-1:0] RF_TAG_FREE = {RF_TAG_WIDTH{1'b1}};
    localparam logic [RF_REG_WIDTH-1:0] RF_ZERO_REG = '0;

endpackage

// File: rtl/reg_file_rename_read_port.sv
// Combinational operand read path: enable gating, x0 handling and commit bypass.
module reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = RF_REG_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = RF_TAG_WIDTH
) (
    input  logic                  i_en,
    input  logic [REG_WIDTH-1:0]  i_addr,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_cmt_en,
    input  logic [REG_WIDTH-1:0]  i_cmt_addr,
    input  logic [TAG_WIDTH-1:0]  i_cmt_tag,
    input  logic [DATA_WIDTH-1:0] i_cmt_data,
    output logic [TAG_WIDTH-1:0]  o_tag_c,
    output logic [DATA_WIDTH-1:0] o_data_c
);

    localparam logic [TAG_WIDTH-1:0] TAG_FREE = {TAG_WIDTH{1'b1}};

    logic w_hit;
    logic w_bypass;

    assign w_hit    = i_en && (i_addr != '0);
    assign w_bypass = i_cmt_en && (i_cmt_addr == i_addr) && (i_tag == i_cmt_tag);

    // Select disabled/x0 constant, committing value, or stored state.
    always_comb begin
        o_tag_c  = TAG_FREE;
        o_data_c = '0;
        if (w_hit) begin
            if (w_bypass) begin
                o_data_c = i_cmt_data;
            end else begin
                o_tag_c  = i_tag;
                o_data_c = i_data;
            end
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags for the OoO core.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = RF_REG_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = RF_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regEnread1,
    input  logic [REG_WIDTH-1:0]  regAddr1,
    output logic [TAG_WIDTH-1:0]  regTag1,
    output logic [DATA_WIDTH-1:0] regData1,
    input  logic                  regEnread2,
    input  logic [REG_WIDTH-1:0]  regAddr2,
    output logic [TAG_WIDTH-1:0]  regTag2,
    output logic [DATA_WIDTH-1:0] regData2,
    input  logic                  renEn,
    input  logic [REG_WIDTH-1:0]  renAddr,
    input  logic [TAG_WIDTH-1:0]  renTag,
    input  logic                  cmtEn,
    input  logic [REG_WIDTH-1:0]  cmtAddr,
    input  logic [TAG_WIDTH-1:0]  cmtTag,
    input  logic [DATA_WIDTH-1:0] cmtData,
    input  logic                  flush
);

    localparam int unsigned          NUM_REGS = 1 << REG_WIDTH;
    localparam logic [TAG_WIDTH-1:0] TAG_FREE = {TAG_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] r_data [NUM_REGS];
    logic [TAG_WIDTH-1:0]  r_tag  [NUM_REGS];

    logic w_cmt_wr;
    logic w_ren_wr;

    assign w_cmt_wr = cmtEn && (cmtAddr != '0);
    assign w_ren_wr = renEn && (renAddr != '0) && !flush;

    // State update: flush clears tags, commit writes data and retires a matching tag, rename claims the tag last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= TAG_FREE;
            end
        end else begin
            if (w_cmt_wr) begin
                r_data[cmtAddr] <= cmtData;
            end
            if (flush) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    r_tag[i] <= TAG_FREE;
                end
            end else begin
                if (w_cmt_wr && (r_tag[cmtAddr] == cmtTag)) begin
                    r_tag[cmtAddr] <= TAG_FREE;
                end
                if (w_ren_wr) begin
                    r_tag[renAddr] <= renTag;
                end
            end
        end
    end

    // Read port 1.
    reg_read_port #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_read_port1 (
        .i_en       (regEnread1),
        .i_addr     (regAddr1),
        .i_tag      (r_tag[regAddr1]),
        .i_data     (r_data[regAddr1]),
        .i_cmt_en   (cmtEn),
        .i_cmt_addr (cmtAddr),
        .i_cmt_tag  (cmtTag),
        .i_cmt_data (cmtData),
        .o_tag_c    (regTag1),
        .o_data_c   (regData1)
    );

    // Read port 2.
    reg_read_port #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_read_port2 (
        .i_en       (regEnread2),
        .i_addr     (regAddr2),
        .i_tag      (r_tag[regAddr2]),
        .i_data     (r_data[regAddr2]),
        .i_cmt_en   (cmtEn),
        .i_cmt_addr (cmtAddr),
        .i_cmt_tag  (cmtTag),
        .i_cmt_data (cmtData),
        .o_tag_c    (regTag2),
        .o_data_c   (regData2)
    );

    // A rename must always name a real ROB entry.
    a_ren_tag_legal : assert property (@(posedge clk) disable iff (rst)
        renEn |-> (renTag != TAG_FREE));

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: a reference model predicts each cycle's reads.
module tb_reg_file_rename;
    import reg_file_rename_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     regEnread1, regEnread2;
    logic [RF_REG_WIDTH-1:0]  regAddr1, regAddr2;
    logic [RF_TAG_WIDTH-1:0]  regTag1, regTag2;
    logic [RF_DATA_WIDTH-1:0] regData1, regData2;
    logic                     renEn, cmtEn, flush;
    logic [RF_REG_WIDTH-1:0]  renAddr, cmtAddr;
    logic [RF_TAG_WIDTH-1:0]  renTag, cmtTag;
    logic [RF_DATA_WIDTH-1:0] cmtData;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk        (clk),
        .rst        (rst),
        .regEnread1 (regEnread1),
        .regAddr1   (regAddr1),
        .regTag1    (regTag1),
        .regData1   (regData1),
        .regEnread2 (regEnread2),
        .regAddr2   (regAddr2),
        .regTag2    (regTag2),
        .regData2   (regData2),
        .renEn      (renEn),
        .renAddr    (renAddr),
        .renTag     (renTag),
        .cmtEn      (cmtEn),
        .cmtAddr    (cmtAddr),
        .cmtTag     (cmtTag),
        .cmtData    (cmtData),
        .flush      (flush)
    );

    typedef struct {
        string                    name;
        logic [RF_TAG_WIDTH-1:0]  tag;
        logic [RF_DATA_WIDTH-1:0] data;
    } exp_t;

    exp_t                     sb_q[$];
    logic [RF_DATA_WIDTH-1:0] m_data [RF_NUM_REGS];
    logic [RF_TAG_WIDTH-1:0]  m_tag  [RF_NUM_REGS];
    int                       n_checks = 0;
    int                       n_errors = 0;

    // One comparison: count it and report a mismatch.
    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(RF_NUM_REGS); i++) begin
            m_data[i] = '0;
            m_tag[i]  = RF_TAG_FREE;
        end
    endtask

    // Expected read result for one port given current inputs and model state.
    task automatic model_read(input logic en, input logic [RF_REG_WIDTH-1:0] a,
                              output logic [RF_TAG_WIDTH-1:0] t, output logic [RF_DATA_WIDTH-1:0] d);
        if (!en || a == RF_ZERO_REG) begin
            t = RF_TAG_FREE;
            d = '0;
        end else if (cmtEn && cmtAddr == a && m_tag[a] == cmtTag) begin
            t = RF_TAG_FREE;
            d = cmtData;
        end else begin
            t = m_tag[a];
            d = m_data[a];
        end
    endtask

    task automatic model_update();
        if (cmtEn && cmtAddr != RF_ZERO_REG) m_data[cmtAddr] = cmtData;
        if (flush) begin
            for (int i = 0; i < int'(RF_NUM_REGS); i++) m_tag[i] = RF_TAG_FREE;
        end else begin
            if (cmtEn && cmtAddr != RF_ZERO_REG && m_tag[cmtAddr] == cmtTag) m_tag[cmtAddr] = RF_TAG_FREE;
            if (renEn && renAddr != RF_ZERO_REG) m_tag[renAddr] = renTag;
        end
    endtask

    task automatic idle();
        regEnread1 = 1'b0; regAddr1 = '0;
        regEnread2 = 1'b0; regAddr2 = '0;
        renEn = 1'b0; renAddr = '0; renTag = '0;
        cmtEn = 1'b0; cmtAddr = '0; cmtTag = '0; cmtData = '0;
        flush = 1'b0;
    endtask

    task automatic rd(input logic [RF_REG_WIDTH-1:0] a1, input logic [RF_REG_WIDTH-1:0] a2);
        regEnread1 = 1'b1; regAddr1 = a1;
        regEnread2 = 1'b1; regAddr2 = a2;
    endtask

    // Push expected reads for the driven inputs, let logic settle, then pop and compare.
    task automatic sample(input string name);
        exp_t e1, e2, g;
        e1.name = {name, "_p1"};
        e2.name = {name, "_p2"};
        model_read(regEnread1, regAddr1, e1.tag, e1.data);
        model_read(regEnread2, regAddr2, e2.tag, e2.data);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        #1;
        g = sb_q.pop_front();
        check_eq({g.name, "_tag"}, 64'(regTag1), 64'(g.tag));
        check_eq({g.name, "_data"}, 64'(regData1), 64'(g.data));
        g = sb_q.pop_front();
        check_eq({g.name, "_tag"}, 64'(regTag2), 64'(g.tag));
        check_eq({g.name, "_data"}, 64'(regData2), 64'(g.data));
    endtask

    // Commit the cycle at the rising edge, then return to the falling edge for the next drive.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);

        // Reset state reads.
        rd(5'd5, 5'd0);
        sample("t1_reset");
        check_eq("t1_tag1", 64'(regTag1), 64'hF);
        check_eq("t1_data1", 64'(regData1), 64'h0);
        rst = 1'b0;
        tick();

        // Rename then matching commit with same-cycle bypass.
        renEn = 1'b1; renAddr = 5'd3; renTag = 4'd2; rd(5'd3, 5'd3);
        sample("t2_ren");
        check_eq("t2_ren_sees_prior", 64'(regTag1), 64'hF);
        tick();
        rd(5'd3, 5'd0);
        sample("t2_pend");
        check_eq("t2_pend_tag", 64'(regTag1), 64'h2);
        tick();
        cmtEn = 1'b1; cmtAddr = 5'd3; cmtTag = 4'd2; cmtData = 32'hDEADBEEF; rd(5'd3, 5'd3);
        sample("t2_byp");
        check_eq("t2_byp_tag", 64'(regTag2), 64'hF);
        check_eq("t2_byp_data", 64'(regData2), 64'hDEADBEEF);
        tick();
        rd(5'd3, 5'd3);
        sample("t2_after");
        check_eq("t2_after_data", 64'(regData1), 64'hDEADBEEF);
        tick();

        // Stale commit keeps the younger producer's tag.
        renEn = 1'b1; renAddr = 5'd4; renTag = 4'd1;
        sample("t3_ren1");
        tick();
        renEn = 1'b1; renAddr = 5'd4; renTag = 4'd6;
        sample("t3_ren2");
        tick();
        cmtEn = 1'b1; cmtAddr = 5'd4; cmtTag = 4'd1; cmtData = 32'h11; rd(5'd4, 5'd4);
        sample("t3_cmt");
        check_eq("t3_cmt_nobyp", 64'(regTag1), 64'h6);
        tick();
        rd(5'd4, 5'd0);
        sample("t3_after");
        check_eq("t3_after_tag", 64'(regTag1), 64'h6);
        check_eq("t3_after_data", 64'(regData1), 64'h11);
        tick();

        // Same-cycle rename and commit on one register.
        renEn = 1'b1; renAddr = 5'd7; renTag = 4'd5;
        sample("t4_pre");
        tick();
        renEn = 1'b1; renAddr = 5'd7; renTag = 4'd3;
        cmtEn = 1'b1; cmtAddr = 5'd7; cmtTag = 4'd5; cmtData = 32'hAA; rd(5'd7, 5'd7);
        sample("t4_same");
        check_eq("t4_same_data", 64'(regData1), 64'hAA);
        tick();
        rd(5'd7, 5'd0);
        sample("t4_after");
        check_eq("t4_after_tag", 64'(regTag1), 64'h3);
        check_eq("t4_after_data", 64'(regData1), 64'hAA);
        tick();

        // Flush with concurrent commit and an ignored rename.
        for (int i = 1; i <= 4; i++) begin
            renEn = 1'b1; renAddr = 5'(i); renTag = 4'(i - 1);
            sample("t5_ren");
            tick();
        end
        flush = 1'b1; cmtEn = 1'b1; cmtAddr = 5'd2; cmtTag = 4'd9; cmtData = 32'h55;
        renEn = 1'b1; renAddr = 5'd5; renTag = 4'd8;
        sample("t5_flush");
        tick();
        rd(5'd2, 5'd5);
        sample("t5_after");
        check_eq("t5_x2_tag", 64'(regTag1), 64'hF);
        check_eq("t5_x2_data", 64'(regData1), 64'h55);
        check_eq("t5_x5_tag", 64'(regTag2), 64'hF);
        tick();
        rd(5'd1, 5'd4);
        sample("t5_after2");
        tick();

        // Writes to x0 are discarded.
        renEn = 1'b1; renAddr = 5'd0; renTag = 4'd2;
        cmtEn = 1'b1; cmtAddr = 5'd0; cmtTag = 4'hF; cmtData = 32'hFF;
        sample("t6_x0w");
        tick();
        rd(5'd0, 5'd0);
        sample("t6_x0r");
        check_eq("t6_x0_data", 64'(regData1), 64'h0);
        tick();

        // Disabled port hides a pending register.
        renEn = 1'b1; renAddr = 5'd6; renTag = 4'd4;
        sample("t6_ren");
        tick();
        regEnread1 = 1'b0; regAddr1 = 5'd6; regEnread2 = 1'b1; regAddr2 = 5'd6;
        sample("t6_en");
        check_eq("t6_en_off_tag", 64'(regTag1), 64'hF);
        check_eq("t6_en_on_tag", 64'(regTag2), 64'h4);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        regEnread1 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_tag", 64'(regTag1), 64'hF);
        check_eq("t6_rst_data3", 64'(regData2), 64'h0);
        regAddr2 = 5'd3;
        #1;
        check_eq("t6_rst_x3", 64'(regData2), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            regEnread1 = 1'($urandom_range(0, 7) != 0);
            regAddr1   = 5'($urandom_range(0, 7));
            regEnread2 = 1'($urandom_range(0, 7) != 0);
            regAddr2   = 5'($urandom_range(0, 7));
            renEn      = 1'($urandom_range(0, 1));
            renAddr    = 5'($urandom_range(0, 7));
            renTag     = 4'($urandom_range(0, 14));
            cmtEn      = 1'($urandom_range(0, 1));
            cmtAddr    = 5'($urandom_range(0, 7));
            cmtTag     = ($urandom_range(0, 2) != 0) ? m_tag[cmtAddr] : 4'($urandom_range(0, 15));
            cmtData    = 32'($urandom);
            flush      = 1'($urandom_range(0, 15) == 0);
            sample("rand");
            tick();
        end

        check_eq("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags for the Tomasulo-style out-of-order core.
- Responder to the decoder's two source-operand read ports: returns data when a register is ready, or the ROB tag of its pending producer otherwise.
- Also accepts destination renames from issue, commit writes from the ROB, and a flush on misprediction.

Parameters:
- REG_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 32, register data width.
- TAG_WIDTH, 4, ROB tag width; the all-ones value is TAG_FREE ("no pending producer").

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- regEnread1  in  1  read port 1 enable.
- regAddr1  in  REG_WIDTH  read port 1 address.
- regTag1  out  TAG_WIDTH  producer tag for port 1, or TAG_FREE.
- regData1  out  DATA_WIDTH  port 1 data; valid when regTag1 == TAG_FREE.
- regEnread2, regAddr2, regTag2, regData2: same as port 1, for port 2.
- renEn  in  1  rename request from issue.
- renAddr  in  REG_WIDTH  destination register to rename.
- renTag  in  TAG_WIDTH  ROB tag of the new producer.
- cmtEn  in  1  commit write from the ROB.
- cmtAddr  in  REG_WIDTH  commit destination.
- cmtTag  in  TAG_WIDTH  ROB tag of the committing entry.
- cmtData  in  DATA_WIDTH  committed value.
- flush  in  1  misprediction flush; clears all pending tags.

Behaviour:
- Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.
- State:
  - data[0..31], each DATA_WIDTH bits.
  - tag[0..31], each TAG_WIDTH bits.
- Reset (async, immediate):
  - every data = 0, every tag = TAG_FREE.
  - Read outputs follow combinationally from the reset state.
- Reads are combinational, zero latency, so the decoder gets operands in the same cycle it presents addresses.
  - Enable low -> tag output TAG_FREE, data output 0.
  - Address 0 -> TAG_FREE, data 0, always.
  - Otherwise the port returns tag[a] and data[a].
- Commit bypass on reads:
  - Condition: cmtEn, cmtAddr == a, a != 0, and tag[a] == cmtTag.
  - Response: the port returns TAG_FREE and cmtData in the same cycle.
- Reads never observe a same-cycle rename. An instruction with rs == rd sees the prior producer.
- Clocked update, in priority order:
  1. flush: all tags become TAG_FREE.
     - A same-cycle cmtEn still writes data[cmtAddr] when cmtAddr != 0; the tag match is not required.
     - renEn is ignored in a flush cycle.
  2. Commit (cmtEn, cmtAddr != 0):
     - data[cmtAddr] <= cmtData, unconditionally (in-order commit).
     - tag[cmtAddr] <= TAG_FREE only if tag[cmtAddr] == cmtTag; a younger producer keeps its tag.
  3. Rename (renEn, renAddr != 0): tag[renAddr] <= renTag.
     - If it targets the same register as a commit in the same cycle, the rename wins the tag; the commit data is still written.
- Writes to register 0 (rename or commit) are discarded.
- renTag == TAG_FREE is illegal. Checked by assertion only; the RTL writes it as given.
- Both read ports may name the same register and receive identical results.
- Reset asserted mid-operation: all state is cleared immediately; any in-flight rename or commit that cycle is lost.

Decomposition:
- Shared package/defines (alongside the existing width macros):
  - regWidth, dataWidth, tagWidth.
  - tagFree constant.
  - zero-register constant.
- One natural sub-module: reg_read_port. It is the combinational read path with enable, x0 and commit-bypass logic, instantiated twice.
- Storage and update logic stay in the top module.

Test Plan:
1. Reset, then read x5 and x0 on both ports -> regTag = TAG_FREE (4'hF), regData = 0 on both ports.
2. Cycle 1: rename x3 -> tag 2. Cycle 2: read x3 -> regTag1 = 2. Then commit x3, tag 2, data 32'hDEADBEEF -> same-cycle read gives TAG_FREE / 32'hDEADBEEF; next cycle the stored tag is TAG_FREE.
3. Rename x4 -> tag 1, then x4 -> tag 6. Commit x4, tag 1, data 32'h11 -> data[4] = 32'h11 but tag stays 6; a read returns tag 6 with no bypass.
4. Same cycle: rename x7 -> tag 3, commit x7 (matching old tag 5) with data 32'hAA, and read x7 -> read returns TAG_FREE / 32'hAA (bypass). Next cycle tag[7] = 3, data = 32'hAA.
5. Rename x1..x4 to tags 0..3, then flush with a simultaneous commit of x2, data 32'h55 -> all tags TAG_FREE, data[2] = 32'h55, and no rename is applied that cycle.
6. Rename x0 -> tag 2, and commit x0 with data 32'hFF -> reading x0 still gives TAG_FREE / 0. Assert rst mid-stream with tags pending -> all outputs reset immediately, without waiting for a clock edge.
